tff_bank_counter: RTL and testbench

Parametrised successor to the single toggle flip-flop: a WIDTH-bit register of toggle stages that runs either as an independent T-flip-flop bank or as a modulo-MODULUS up/down counter, with synchronous load and clear. It serves as the general-purpose divider, event counter and toggle bank for the behavioural-modelling library. It provides complementary outputs per bit, a combinational terminal-count flag and a registered wrap pulse.

---
 rtl/tff_bank_counter.sv | 61 ++++++
 tb/tb_tff_bank_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/tff_bank_counter.sv
// tff_bank_counter: WIDTH-bit toggle bank / modulo-MODULUS up-down counter with load, clear, tc and wrap.
// Define TFF_BANK_SATURATE_EN for saturating counter modes with a sticky saturation flag on wrap.
module tff_bank_counter #(
  parameter int WIDTH = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] q_q, q_d, up_nxt, dn_nxt;
  logic             wrap_q, wrap_d;
  logic             at_top, at_zero;
  assign at_top  = q_q >= TOP;
  assign at_zero = q_q == '0;
  assign tc = en && !sclr && !load && ((mode == 2'b01 && at_top) || (mode == 2'b10 && at_zero));
`ifdef TFF_BANK_SATURATE_EN
  assign up_nxt = at_top ? TOP : q_q + ONE;
  assign dn_nxt = at_zero ? '0 : q_q - ONE;
`else
  assign up_nxt = at_top ? '0 : q_q + ONE;
  assign dn_nxt = at_zero ? TOP : q_q - ONE;
`endif
  always_comb begin
    q_d = sclr ? '0 :
          load ? d :
          !en ? q_q :
          mode == 2'b00 ? q_q ^ t :
          mode == 2'b01 ? up_nxt :
          mode == 2'b10 ? dn_nxt : q_q;
`ifdef TFF_BANK_SATURATE_EN
    wrap_d = (sclr || load) ? 1'b0 : (wrap_q || tc);
`else
    wrap_d = tc;
`endif
  end
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end
  // qb is derived from the same flops so it can never disagree with q
  assign q    = q_q;
  assign qb   = ~q_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_tff_bank_counter.sv
// tb_tff_bank_counter: directed checks of tff_bank_counter with WIDTH=8, MODULUS=10.
module tb_tff_bank_counter;
  logic       clk = 1'b0;
  logic       clear_n, en, sclr, load, tc, wrap;
  logic [1:0] mode;
  logic [7:0] t, d, q, qb;
  int checks = 0;
  int errors = 0;

  tff_bank_counter #(.WIDTH(8), .MODULUS(10)) dut (
    .clk(clk), .clear_n(clear_n), .en(en), .mode(mode), .t(t), .sclr(sclr),
    .load(load), .d(d), .q(q), .qb(qb), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_n = 1'b0; en = 1'b0; mode = 2'b00; t = '0; sclr = 1'b0; load = 1'b0; d = '0;
    #3;
    chk("rst_q", q, 0);
    chk("rst_qb", qb, 8'hFF);
    chk("rst_wrap", wrap, 0);
    #9 clear_n = 1'b1;
    en = 1'b1; mode = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    chk("cnt5_q", q, 5);
    #2 clear_n = 1'b0;
    #1;
    chk("midrst_q", q, 0);
    chk("midrst_qb", qb, 8'hFF);
    chk("midrst_wrap", wrap, 0);
    #1 clear_n = 1'b1;
    tick();
    chk("postrst_q", q, 1);
`ifdef TFF_BANK_SATURATE_EN
    sclr = 1'b1; tick(); sclr = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("sat_q", q, (i > 9) ? 9 : i);
      chk("sat_wrap", wrap, (i >= 10) ? 1 : 0);
    end
    chk("sat_tc", tc, 1);
    sclr = 1'b1; tick(); sclr = 1'b0;
    chk("sat_clr_q", q, 0);
    chk("sat_clr_wrap", wrap, 0);
`else
    sclr = 1'b1; tick(); sclr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("up_q", q, i);
      chk("up_tc", tc, (i == 9) ? 1 : 0);
      tick();
    end
    chk("up_wrapq", q, 0);
    chk("up_wrap1", wrap, 1);
    tick();
    chk("up_q1", q, 1);
    chk("up_wrap0", wrap, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("up_q9", q, 9);
    chk("up_tc9", tc, 1);
    tick();
    chk("period_q", q, 0);
    chk("period_wrap", wrap, 1);
    load = 1'b1; d = 8'h0C; tick(); load = 1'b0;
    chk("ld_oor_q", q, 8'h0C);
    chk("ld_wrap", wrap, 0);
    mode = 2'b10;
    for (int v = 11; v >= 0; v--) begin
      tick();
      chk("dn_q", q, v);
      chk("dn_wrap", wrap, 0);
    end
    chk("dn_tc", tc, 1);
    tick();
    chk("dn_wrapq", q, 9);
    chk("dn_wrap1", wrap, 1);
    tick();
    chk("dn_q8", q, 8);
    chk("dn_wrap0", wrap, 0);
`endif
    sclr = 1'b1; tick(); sclr = 1'b0;
    mode = 2'b00;
    t = 8'h0A; tick();
    chk("tg1_q", q, 8'h0A); chk("tg1_qb", qb, 8'hF5); chk("tg1_wrap", wrap, 0);
    t = 8'h05; tick();
    chk("tg2_q", q, 8'h0F); chk("tg2_wrap", wrap, 0);
    t = 8'h0A; tick();
    chk("tg3_q", q, 8'h05); chk("tg3_wrap", wrap, 0);
    t = 8'h05; tick();
    chk("tg4_q", q, 8'h00); chk("tg4_wrap", wrap, 0);
    t = '0;
    load = 1'b1; d = 8'h09; tick(); load = 1'b0;
    sclr = 1'b1; tick(); sclr = 1'b0;
    load = 1'b1; d = 8'h09; tick(); load = 1'b0;
    mode = 2'b01;
    #1;
    chk("pri_tc_pre", tc, 1);
    sclr = 1'b1; load = 1'b1; d = 8'h03;
    #1;
    chk("pri_tc", tc, 0);
    tick();
    chk("pri_q", q, 0);
    chk("pri_wrap", wrap, 0);
    sclr = 1'b0;
    tick();
    chk("ld_q", q, 3);
    load = 1'b0; en = 1'b0;
    tick();
    chk("en0_q", q, 3);
    chk("en0_tc", tc, 0);
    en = 1'b1; mode = 2'b11;
    tick();
    chk("hold_q", q, 3);
    chk("hold_qb", qb, 8'hFC);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
